// File: rtl/alu_sched_pkg.sv
// rtl/alu_sched_pkg.sv - shared opcodes, FSM states and defaults for alu_sched
package alu_sched_pkg;

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_XOR = 3'b010;
  localparam logic [2:0] OP_NOR = 3'b011;
  localparam logic [2:0] OP_SLT = 3'b100;
  localparam logic [2:0] OP_ADD = 3'b101;
  localparam logic [2:0] OP_SUB = 3'b110;
  localparam logic [2:0] OP_MOD = 3'b111;

  localparam int unsigned TIMEOUT_CYC_DEF = 64;

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    WAIT_MOD,
    RESP
  } state_e;

endpackage

// File: rtl/alu_sched_rr_arb2.sv
// rtl/alu_sched_rr_arb2.sv - two-way round-robin arbiter with pointer update on accept
module rr_arb2 (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       accept,
  output logic [1:0] gnt
);

  // ptr_q names the requester that wins a tie
  logic ptr_q, ptr_d;

  // Tie goes to the pointer; after a grant the other requester gets priority
  always_comb begin
    gnt   = req;
    ptr_d = ptr_q;
    if (req == 2'b11) begin
      gnt = ptr_q ? 2'b10 : 2'b01;
    end
    if (accept && (gnt != 2'b00)) begin
      ptr_d = gnt[0];
    end
  end

  // Pointer register, requester 0 favoured out of reset
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ptr_q <= 1'b0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/alu_sched.sv
// rtl/alu_sched.sv - two-requester ALU scheduler; MOD watchdog under ALU_SCHED_TIMEOUT_EN
module alu_sched
  import alu_sched_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       req_valid,
  output logic [1:0]       req_ready,
  input  logic [1:0][31:0] req_a,
  input  logic [1:0][31:0] req_b,
  input  logic [1:0][2:0]  req_op,
  output logic [31:0]      alu_a,
  output logic [31:0]      alu_b,
  output logic [2:0]       alu_op,
  output logic             alu_start,
  input  logic [31:0]      alu_res,
  input  logic             alu_done,
  input  logic             alu_carry,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [31:0]      rsp_res,
  output logic             rsp_carry,
  output logic             rsp_err
);

  state_e      state_q, state_d;
  logic [31:0] hold_a_q, hold_a_d;
  logic [31:0] hold_b_q, hold_b_d;
  logic [2:0]  hold_op_q, hold_op_d;
  logic        hold_id_q, hold_id_d;
  logic [31:0] rsp_res_q, rsp_res_d;
  logic        rsp_carry_q, rsp_carry_d;
  logic [1:0]  gnt;
  logic        accept;

`ifdef ALU_SCHED_TIMEOUT_EN
  localparam int unsigned    WDW     = $clog2(TIMEOUT_CYC) + 1;
  localparam logic [WDW-1:0] WD_LAST = WDW'(TIMEOUT_CYC - 1);
  logic [WDW-1:0] wdog_q, wdog_d;
  logic           rsp_err_q, rsp_err_d;
`endif

  rr_arb2 u_arb (
    .clk    (clk),
    .reset  (reset),
    .req    (req_valid),
    .accept (accept),
    .gnt    (gnt)
  );

  // Next-state, holding/response register updates and strobes for the scheduler FSM
  always_comb begin
    state_d     = state_q;
    hold_a_d    = hold_a_q;
    hold_b_d    = hold_b_q;
    hold_op_d   = hold_op_q;
    hold_id_d   = hold_id_q;
    rsp_res_d   = rsp_res_q;
    rsp_carry_d = rsp_carry_q;
    req_ready   = 2'b00;
    alu_start   = 1'b0;
    accept      = 1'b0;
`ifdef ALU_SCHED_TIMEOUT_EN
    wdog_d      = wdog_q;
    rsp_err_d   = rsp_err_q;
`endif
    case (state_q)
      IDLE: begin
        if (req_valid != 2'b00) begin
          accept    = 1'b1;
          req_ready = gnt;
          hold_id_d = gnt[1];
          hold_a_d  = gnt[1] ? req_a[1]  : req_a[0];
          hold_b_d  = gnt[1] ? req_b[1]  : req_b[0];
          hold_op_d = gnt[1] ? req_op[1] : req_op[0];
          state_d   = EXEC;
        end
      end
      EXEC: begin
        if (hold_op_q == OP_MOD) begin
          alu_start = 1'b1;
`ifdef ALU_SCHED_TIMEOUT_EN
          wdog_d    = '0;
`endif
          state_d   = WAIT_MOD;
        end else begin
          rsp_res_d   = alu_res;
          rsp_carry_d = alu_carry && (hold_op_q == OP_ADD);
`ifdef ALU_SCHED_TIMEOUT_EN
          rsp_err_d   = 1'b0;
`endif
          state_d     = RESP;
        end
      end
      WAIT_MOD: begin
        if (alu_done) begin
          rsp_res_d   = alu_res;
          rsp_carry_d = 1'b0;
`ifdef ALU_SCHED_TIMEOUT_EN
          rsp_err_d   = 1'b0;
`endif
          state_d     = RESP;
        end
`ifdef ALU_SCHED_TIMEOUT_EN
        else if (wdog_q == WD_LAST) begin
          rsp_res_d   = '0;
          rsp_carry_d = 1'b0;
          rsp_err_d   = 1'b1;
          state_d     = RESP;
        end else begin
          wdog_d = wdog_q + 1'b1;
        end
`endif
      end
      RESP: begin
        if (rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, operand holding and response registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      hold_a_q    <= '0;
      hold_b_q    <= '0;
      hold_op_q   <= '0;
      hold_id_q   <= 1'b0;
      rsp_res_q   <= '0;
      rsp_carry_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      hold_a_q    <= hold_a_d;
      hold_b_q    <= hold_b_d;
      hold_op_q   <= hold_op_d;
      hold_id_q   <= hold_id_d;
      rsp_res_q   <= rsp_res_d;
      rsp_carry_q <= rsp_carry_d;
    end
  end

`ifdef ALU_SCHED_TIMEOUT_EN
  // Watchdog counter and timeout flag
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wdog_q    <= '0;
      rsp_err_q <= 1'b0;
    end else begin
      wdog_q    <= wdog_d;
      rsp_err_q <= rsp_err_d;
    end
  end
  assign rsp_err = rsp_err_q;
`else
  assign rsp_err = 1'b0;
`endif

  assign alu_a     = hold_a_q;
  assign alu_b     = hold_b_q;
  assign alu_op    = hold_op_q;
  assign rsp_valid = (state_q == RESP);
  assign rsp_id    = hold_id_q;
  assign rsp_res   = rsp_res_q;
  assign rsp_carry = rsp_carry_q;

endmodule

// File: tb/tb_alu_sched.sv
// tb/tb_alu_sched.sv - self-checking bench for alu_sched (watchdog case under ALU_SCHED_TIMEOUT_EN)
module tb_alu_sched;
  import alu_sched_pkg::*;

  typedef struct {
    logic        id;
    logic [31:0] res;
    logic        carry;
    logic        err;
  } rsp_t;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic        carry;
  } vec_t;

  logic             clk = 1'b0;
  logic             reset;
  logic [1:0]       req_valid;
  logic [1:0]       req_ready;
  logic [1:0][31:0] req_a;
  logic [1:0][31:0] req_b;
  logic [1:0][2:0]  req_op;
  logic [31:0]      alu_a, alu_b, alu_res;
  logic [2:0]       alu_op;
  logic             alu_start, alu_done, alu_carry;
  logic             rsp_valid, rsp_ready, rsp_id, rsp_carry, rsp_err;
  logic [31:0]      rsp_res;

  int   n_cmp = 0;
  int   n_bad = 0;
  int   n_start = 0;
  int   n_rspv = 0;
  int   mod_delay = 0;
  int   mod_cnt = 0;
  logic done_force = 1'b0;
  logic [32:0] sum33;
  rsp_t sb[$];
  rsp_t mon_e;
  int   grant_log[$];
  vec_t vecs[10];

  alu_sched dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_op    (req_op),
    .alu_a     (alu_a),
    .alu_b     (alu_b),
    .alu_op    (alu_op),
    .alu_start (alu_start),
    .alu_res   (alu_res),
    .alu_done  (alu_done),
    .alu_carry (alu_carry),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_res   (rsp_res),
    .rsp_carry (rsp_carry),
    .rsp_err   (rsp_err)
  );

  always #5 clk = ~clk;

  // ALU model: carry is always the adder carry so the scheduler must mask it
  always_comb begin
    sum33     = {1'b0, alu_a} + {1'b0, alu_b};
    alu_carry = sum33[32];
    alu_res   = '0;
    case (alu_op)
      OP_AND: alu_res = alu_a & alu_b;
      OP_OR:  alu_res = alu_a | alu_b;
      OP_XOR: alu_res = alu_a ^ alu_b;
      OP_NOR: alu_res = ~(alu_a | alu_b);
      OP_SLT: alu_res = {31'b0, $signed(alu_a) < $signed(alu_b)};
      OP_ADD: alu_res = sum33[31:0];
      OP_SUB: alu_res = alu_a - alu_b;
      default: alu_res = (alu_b != 0) ? (alu_a % alu_b) : 32'h0;
    endcase
  end

  always @(posedge clk) begin
    if (alu_start) mod_cnt <= mod_delay;
    else if (mod_cnt > 0) mod_cnt <= mod_cnt - 1;
  end
  assign alu_done = (mod_cnt == 1) || done_force;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic bound_fail(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: wait bound expired", name);
  endtask

  // Scoreboard: pop and compare on each accepted response
  always @(negedge clk) begin
    if (alu_start) n_start++;
    if (rsp_valid) n_rspv++;
    if (reset && rsp_valid && rsp_ready) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_rsp: got id=%0d res=%h want none", rsp_id, rsp_res);
      end else begin
        mon_e = sb.pop_front();
        chk("rsp_id", {31'b0, rsp_id}, {31'b0, mon_e.id});
        chk("rsp_res", rsp_res, mon_e.res);
        chk("rsp_carry", {31'b0, rsp_carry}, {31'b0, mon_e.carry});
        chk("rsp_err", {31'b0, rsp_err}, {31'b0, mon_e.err});
      end
    end
  end

  task automatic push_exp(input logic id, input logic [31:0] res, input logic carry, input logic err);
    rsp_t e;
    e.id = id; e.res = res; e.carry = carry; e.err = err;
    sb.push_back(e);
  endtask

  task automatic issue(input logic id, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] eres, input logic ecarry, input logic eerr, input bit expect_rsp);
    int n = 0;
    bit ok = 0;
    req_a[id] = a; req_b[id] = b; req_op[id] = op; req_valid[id] = 1'b1;
    while (!ok && n < 100) begin
      @(negedge clk);
      if (req_ready[id]) ok = 1;
      n++;
    end
    if (!ok) bound_fail("grant_wait");
    else if (expect_rsp) push_exp(id, eres, ecarry, eerr);
    @(posedge clk); #1;
    req_valid[id] = 1'b0;
  endtask

  // Both requesters raise valid together: req0 AND, req1 OR
  task automatic issue_both();
    logic [1:0] got = 2'b00;
    int n = 0;
    req_a[0] = 32'hFFFF00FF; req_b[0] = 32'h0F0F0F0F; req_op[0] = OP_AND;
    req_a[1] = 32'h00000001; req_b[1] = 32'h00000100; req_op[1] = OP_OR;
    req_valid = 2'b11;
    while (got != 2'b11 && n < 100) begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        if (req_ready[i] && !got[i]) begin
          got[i] = 1'b1;
          grant_log.push_back(i);
          if (i == 0) push_exp(1'b0, 32'h0F0F000F, 1'b0, 1'b0);
          else        push_exp(1'b1, 32'h00000101, 1'b0, 1'b0);
        end
      end
      @(posedge clk); #1;
      req_valid = req_valid & ~got;
      n++;
    end
    if (got != 2'b11) bound_fail("both_grant_wait");
    req_valid = 2'b00;
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      bound_fail("rsp_drain");
      sb.delete();
    end
    @(posedge clk); #1;
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

  initial begin
    int k;
    int exp_log[6];
    vecs[0] = '{OP_AND, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 1'b0};
    vecs[1] = '{OP_OR,  32'h12340000, 32'h00005678, 32'h12345678, 1'b0};
    vecs[2] = '{OP_XOR, 32'hFFFF0000, 32'h0F0F0F0F, 32'hF0F00F0F, 1'b0};
    vecs[3] = '{OP_NOR, 32'h0000FFFF, 32'h00FF0000, 32'hFF000000, 1'b0};
    vecs[4] = '{OP_SLT, 32'hFFFFFFFF, 32'h00000001, 32'h00000001, 1'b0};
    vecs[5] = '{OP_SLT, 32'h00000001, 32'hFFFFFFFF, 32'h00000000, 1'b0};
    vecs[6] = '{OP_ADD, 32'h80000000, 32'h80000000, 32'h00000000, 1'b1};
    vecs[7] = '{OP_ADD, 32'h00000005, 32'h00000007, 32'h0000000C, 1'b0};
    vecs[8] = '{OP_SUB, 32'hFFFFFFFF, 32'h00000001, 32'hFFFFFFFE, 1'b0};
    vecs[9] = '{OP_MOD, 32'hFFFFFFFF, 32'h0000000A, 32'h00000005, 1'b0};
    exp_log = '{0, 1, 0, 1, 1, 0};

    reset = 1'b0; req_valid = 2'b00; req_a = '0; req_b = '0; req_op = '0; rsp_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_req_ready", {30'b0, req_ready}, 32'h0);
    chk("rst_alu_start", {31'b0, alu_start}, 32'h0);
    chk("rst_rsp_valid", {31'b0, rsp_valid}, 32'h0);
    chk("rst_rsp_fields", {rsp_res[28:0], rsp_id, rsp_carry, rsp_err}, 32'h0);
    chk("rst_alu_ops", alu_a | alu_b | {29'b0, alu_op}, 32'h0);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;

    // Round-robin order from reset, then a tie right after a lone req0 grant
    issue_both();
    drain();
    issue_both();
    drain();
    issue(1'b0, OP_AND, 32'hFFFF00FF, 32'h0F0F0F0F, 32'h0F0F000F, 1'b0, 1'b0, 1'b1);
    drain();
    issue_both();
    drain();
    chk("grant_count", grant_log.size(), 6);
    for (int i = 0; i < 6 && i < grant_log.size(); i++) chk($sformatf("grant_order[%0d]", i), grant_log[i], exp_log[i]);

    // ADD with carry out: response two cycles after the grant
    issue(1'b0, OP_ADD, 32'hFFFFFFFF, 32'h00000001, 32'h0, 1'b1, 1'b0, 1'b1);
    @(negedge clk);
    chk("add_lat_exec", {31'b0, rsp_valid}, 32'h0);
    @(negedge clk);
    chk("add_lat_resp", {31'b0, rsp_valid}, 32'h1);
    drain();

    // Opcode table, alternating requesters
    mod_delay = 3;
    for (int i = 0; i < 10; i++) begin
      issue(i[0], vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].res, vecs[i].carry, 1'b0, 1'b1);
      drain();
    end

    // Stray alu_done while idle must not produce a response
    n_rspv = 0;
    done_force = 1'b1;
    @(posedge clk); #1;
    done_force = 1'b0;
    repeat (3) @(negedge clk);
    chk("stray_done_rsp", n_rspv, 0);
    @(posedge clk); #1;

    // Requester 1 modulo op completing after 10 cycles
    mod_delay = 10;
    n_start = 0;
    issue(1'b1, OP_MOD, 32'd17, 32'd5, 32'd2, 1'b0, 1'b0, 1'b1);
    drain();
    chk("mod_start_pulses", n_start, 1);

    // Back-pressure in RESP with a pending request on the other port
    rsp_ready = 1'b0;
    issue(1'b0, OP_XOR, 32'h0000FFFF, 32'h00FF00FF, 32'h00FFFF00, 1'b0, 1'b0, 1'b1);
    req_a[1] = 32'h1; req_b[1] = 32'h2; req_op[1] = OP_OR; req_valid[1] = 1'b1;
    k = 0;
    while (!rsp_valid && k < 20) begin
      @(negedge clk);
      k++;
    end
    if (!rsp_valid) bound_fail("hold_rsp_wait");
    for (int i = 0; i < 5; i++) begin
      chk("hold_valid", {31'b0, rsp_valid}, 32'h1);
      chk("hold_res", rsp_res, 32'h00FFFF00);
      chk("hold_id", {31'b0, rsp_id}, 32'h0);
      chk("hold_no_ready", {30'b0, req_ready}, 32'h0);
      @(negedge clk);
    end
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    issue(1'b1, OP_OR, 32'h1, 32'h2, 32'h3, 1'b0, 1'b0, 1'b1);
    drain();

`ifdef ALU_SCHED_TIMEOUT_EN
    // Modulo op whose done never arrives: watchdog response after 64 WAIT_MOD cycles
    mod_delay = 0;
    issue(1'b1, OP_MOD, 32'd17, 32'd5, 32'h0, 1'b0, 1'b1, 1'b1);
    @(negedge clk);
    chk("to_start", {31'b0, alu_start}, 32'h1);
    k = 0;
    while (!rsp_valid && k < 200) begin
      @(negedge clk);
      k++;
    end
    chk("to_latency", k, 65);
    drain();
`endif

    // Reset while waiting on a MOD: op is dropped without a response
    mod_delay = 0;
    issue(1'b1, OP_MOD, 32'd17, 32'd5, 32'h0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    chk("abort_start", {31'b0, alu_start}, 32'h1);
    repeat (3) @(negedge clk);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("abort_rsp_valid", {31'b0, rsp_valid}, 32'h0);
    chk("abort_alu_start", {31'b0, alu_start}, 32'h0);
    chk("abort_rsp_fields", {rsp_res[28:0], rsp_id, rsp_carry, rsp_err}, 32'h0);
    chk("abort_alu_ops", alu_a | alu_b | {29'b0, alu_op}, 32'h0);
    chk("abort_req_ready", {30'b0, req_ready}, 32'h0);
    @(posedge clk); #1;
    reset = 1'b1;
    n_rspv = 0;
    repeat (20) @(negedge clk);
    chk("abort_no_rsp", n_rspv, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/alu_sched.md
ALU_SCHED -- requirements
Module: alu_sched

Interface
REQ-001 Parameter: TIMEOUT_CYC, default 64, max cycles to wait for alu_done on a MOD op.
REQ-002 clk  input  1  single clock; all state on rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 req_valid  input  2  per-requester request valid (bit 0 = requester 0, bit 1 = requester 1).
REQ-005 req_ready  output  2  per-requester accept, one-cycle pulse on grant.
REQ-006 req_a, req_b  input  2x32 each  per-requester operands.
REQ-007 req_op  input  2x3  per-requester ALU opcode.
REQ-008 alu_a, alu_b  output  32 each  operands driven to the ALU.
REQ-009 alu_op  output  3  opcode driven to the ALU.
REQ-010 alu_start  output  1  MOD start pulse to the ALU.
REQ-011 alu_res  input  32  ALU result.
REQ-012 alu_done  input  1  ALU MOD completion.
REQ-013 alu_carry  input  1  ALU adder carry.
REQ-014 rsp_valid  output  1  response valid.
REQ-015 rsp_ready  input  1  response accept.
REQ-016 rsp_id  output  1  requester index of the response.
REQ-017 rsp_res  output  32  captured result.
REQ-018 rsp_carry  output  1  captured carry; forced 0 unless opcode is ADD.
REQ-019 rsp_err  output  1  MOD timeout flag.

Function
REQ-020 Opcodes: 000 AND, 001 OR, 010 XOR, 011 NOR, 100 SLT, 101 ADD, 110 SUB, 111 MOD; only MOD is multi-cycle.
REQ-021 FSM states: IDLE, EXEC, WAIT_MOD, RESP; one request in flight at a time.
REQ-022 IDLE: any req_valid -> grant one requester, pulse its req_ready, latch a/b/op/id into holding registers, go to EXEC.
REQ-023 Arbitration: round-robin; on simultaneous requests, grant the requester not granted last; after reset, requester 0 has priority.
REQ-024 alu_a/alu_b/alu_op driven from holding registers at all times; stable from EXEC until leaving WAIT_MOD.
REQ-025 EXEC with non-MOD op: capture alu_res/alu_carry into rsp registers, go to RESP; rsp_valid rises 2 cycles after the req_ready pulse.
REQ-026 EXEC with MOD: assert alu_start for exactly this one cycle, clear watchdog, go to WAIT_MOD.
REQ-027 WAIT_MOD: on alu_done capture alu_res, rsp_carry=0, rsp_err=0, go to RESP; alu_done outside WAIT_MOD is ignored.
REQ-028 RESP: rsp_valid=1 and rsp_* held stable until rsp_ready sampled high; then IDLE on the next cycle.
REQ-029 req_ready never asserted outside IDLE; requests arriving while busy wait with valid held.
REQ-030 rsp_ready high outside RESP has no effect.

Reset
REQ-031 On reset low: state=IDLE, req_ready=0, alu_start=0, rsp_valid=0, rsp_id=0, rsp_res=0, rsp_carry=0, rsp_err=0, holding registers=0, round-robin pointer=requester 0.
REQ-032 Reset mid-operation (any state) aborts the op; no response is ever emitted for it.

Configuration
REQ-033 Macro ALU_SCHED_TIMEOUT_EN defined: watchdog counts WAIT_MOD cycles; on reaching TIMEOUT_CYC without alu_done, go to RESP with rsp_res=0, rsp_err=1.
REQ-034 Macro undefined: no watchdog logic; WAIT_MOD waits indefinitely; rsp_err tied 0.

Structure
REQ-035 Shared package alu_sched_pkg holds the opcode constants, FSM state enum, and default TIMEOUT_CYC.
REQ-036 One sub-module rr_arb2: 2-way round-robin arbiter (request in, one-hot grant out, pointer update on accept).

Verification
REQ-037 Req0 ADD a=0xFFFFFFFF b=1 -> req_ready[0] pulse, rsp_valid 2 cycles later, rsp_res=0, rsp_carry=1, rsp_id=0.
REQ-038 Both request together (req0 AND, req1 OR), then again -> grant order 0,1,0,1 starting from reset.
REQ-039 Req1 MOD a=17 b=5, ALU model asserts done after 10 cycles -> single alu_start pulse, rsp_res=2, rsp_err=0, rsp_id=1.
REQ-040 rsp_ready held low 5 cycles in RESP -> rsp_* stable, req_ready stays 0 despite pending req_valid.
REQ-041 With ALU_SCHED_TIMEOUT_EN, MOD with done never asserted -> rsp_valid after 64 WAIT_MOD cycles, rsp_err=1, rsp_res=0.
REQ-042 Reset asserted in WAIT_MOD -> all outputs at reset values, no rsp_valid after release until a new request.
